// File: rtl/bus_responder.sv
// bus_responder: single-initiator bus target with a small word RAM and an
// interrupt-pending MMIO block. Each transfer moves IDLE -> (WAIT) -> ACK -> HOLD.
//
// Handshake: the initiator raises bus_en with a stable request and holds it
// until bus_ready has pulsed. bus_ready is high for exactly one cycle (ACK),
// and load_data is meaningful only in that cycle. The initiator must then drop
// bus_en before a new request can be accepted.
module bus_responder #(
  parameter int MEM_WORDS = 256,
  parameter int WAIT_CYC  = 1
) (
  input  logic        clk,
  input  logic        reset_h,
  input  logic        bus_en,
  input  logic        bus_wen,
  input  logic [1:0]  bus_size,
  input  logic [15:0] bus_addr,
  input  logic [31:0] store_data,
  output logic        bus_ready,
  output logic [31:0] load_data,
  output logic [1:0]  intr_h,
  input  logic [1:0]  intr_ack,
  output logic [1:0]  o_dbg_state
);

  localparam int         AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_capture;
  logic          w_ack;
  logic [3:0]    r_wait_cnt;

  // Captured request
  logic          r_wen;
  logic [1:0]    r_size;
  logic [15:0]   r_addr;
  logic [31:0]   r_wdata;

  logic [31:0]   r_mem [MEM_WORDS];
  logic [1:0]    r_pending;

  // Decode of the captured request
  logic [AW-1:0] w_idx;
  logic          w_is_mmio;
  logic          w_err;
  logic          w_mmio_set;
  logic          w_mmio_stat;
  logic [31:0]   w_mem_word;
  logic [31:0]   w_shifted;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [31:0]   w_ram_rdata;
  logic [31:0]   w_rdata;
  logic          w_commit;
  logic          w_ram_we;
  logic [1:0]    w_set_bits;

  // State register
  always_ff @(posedge clk) begin
    if (reset_h) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic; bus_en still high in HOLD never re-arms a transfer
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus_en) begin
          w_capture    = 1'b1;
          w_next_state = (WAIT_CYC > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) w_next_state = ST_ACK;
      end
      ST_ACK: begin
        w_ack        = 1'b1;
        w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus_en) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Wait counter: restarts on each accepted request, advances only in WAIT
  always_ff @(posedge clk) begin
    if (reset_h || w_capture) r_wait_cnt <= 4'd0;
    else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  // Request capture; inputs are ignored outside IDLE
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_wen   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 16'h0000;
      r_wdata <= 32'h0000_0000;
    end else if (w_capture) begin
      r_wen   <= bus_wen;
      r_size  <= bus_size;
      r_addr  <= bus_addr;
      r_wdata <= store_data;
    end
  end

  assign w_idx       = r_addr[AW+1:2];
  assign w_is_mmio   = r_addr[15];
  assign w_mmio_set  = (r_addr[14:2] == 13'd0);
  assign w_mmio_stat = (r_addr[14:2] == 13'd1);
  assign w_err       = (r_size == 2'b11) ||
                       ((r_size == 2'b01) && r_addr[0]) ||
                       ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_mem_word  = r_mem[w_idx];
  assign w_shifted   = w_mem_word >> {r_addr[1:0], 3'b000};

  // Lane steering for writes and right-alignment for reads
  always_comb begin
    w_be        = 4'b0000;
    w_wlanes    = 32'h0000_0000;
    w_ram_rdata = 32'h0000_0000;
    case (r_size)
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wlanes    = {4{r_wdata[7:0]}};
        w_ram_rdata = {24'h000000, w_shifted[7:0]};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes    = {2{r_wdata[15:0]}};
        w_ram_rdata = {16'h0000, w_shifted[15:0]};
      end
      2'b10: begin
        w_be        = 4'b1111;
        w_wlanes    = r_wdata;
        w_ram_rdata = w_shifted;
      end
      default: begin
        w_be        = 4'b0000;
        w_wlanes    = 32'h0000_0000;
        w_ram_rdata = 32'h0000_0000;
      end
    endcase
  end

  // Read mux: errored RAM accesses and unmapped MMIO return zero
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_is_mmio) begin
      if (w_mmio_stat) w_rdata = {30'd0, r_pending};
    end else if (!w_err) begin
      w_rdata = w_ram_rdata;
    end
  end

  // Side effects land on the closing edge of ACK unless reset aborts it
  assign w_commit   = w_ack && r_wen && !reset_h;
  assign w_ram_we   = w_commit && !w_is_mmio && !w_err;
  assign w_set_bits = (w_commit && w_is_mmio && w_mmio_set) ? r_wdata[1:0] : 2'b00;

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // Pending interrupts: acknowledge clears, a simultaneous set wins
  always_ff @(posedge clk) begin
    if (reset_h) r_pending <= 2'b00;
    else         r_pending <= (r_pending & ~intr_ack) | w_set_bits;
  end

  assign bus_ready   = w_ack;
  assign load_data   = w_ack ? w_rdata : 32'h0000_0000;
  assign intr_h      = r_pending;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder (MEM_WORDS=256, WAIT_CYC=1).
module tb_bus_responder;

  logic        clk;
  logic        reset_h;
  logic        bus_en;
  logic        bus_wen;
  logic [1:0]  bus_size;
  logic [15:0] bus_addr;
  logic [31:0] store_data;
  logic        bus_ready;
  logic [31:0] load_data;
  logic [1:0]  intr_h;
  logic [1:0]  intr_ack;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  bus_responder #(
    .MEM_WORDS (256),
    .WAIT_CYC  (1)
  ) dut (
    .clk         (clk),
    .reset_h     (reset_h),
    .bus_en      (bus_en),
    .bus_wen     (bus_wen),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .store_data  (store_data),
    .bus_ready   (bus_ready),
    .load_data   (load_data),
    .intr_h      (intr_h),
    .intr_ack    (intr_ack),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count bus_ready pulses away from the active edge
  always @(negedge clk) begin
    if (bus_ready === 1'b1) n_pulses++;
  end

  // Overall time bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // One full transfer. Returns the cycle count from the bus_en cycle to
  // bus_ready (0 on timeout) and the load_data seen in the ACK cycle.
  // ack_in_ack is driven on intr_ack during the ACK cycle only.
  task automatic bus_xfer(input logic wen, input logic [1:0] size, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [1:0] ack_in_ack,
                          output logic [31:0] rdata, output int lat);
    rdata = 32'h0;
    lat   = 0;
    @(negedge clk);
    bus_en = 1'b1; bus_wen = wen; bus_size = size; bus_addr = addr; store_data = wdata;
    for (int c = 1; c <= 16 && lat == 0; c++) begin
      @(negedge clk);
      if (bus_ready === 1'b1) begin
        lat      = c;
        rdata    = load_data;
        intr_ack = ack_in_ack;
      end else begin
        check("ld_zero_pre_ack", load_data, 32'h0);
      end
    end
    @(negedge clk);
    check("ready_low_hold", {31'd0, bus_ready}, 32'd0);
    check("ld_zero_hold", load_data, 32'h0);
    bus_en = 1'b0; bus_wen = 1'b0; store_data = 32'h0; intr_ack = 2'b00;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  int          lat;
  int          p0;

  initial begin
    reset_h = 1'b1; bus_en = 1'b0; bus_wen = 1'b0; bus_size = 2'b00;
    bus_addr = 16'h0; store_data = 32'h0; intr_ack = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus_ready}, 32'd0);
    check("rst_load", load_data, 32'h0);
    check("rst_intr", {30'd0, intr_h}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset_h = 1'b0;

    // Word write then read-back, latency WAIT_CYC+1
    bus_xfer(1'b1, 2'b10, 16'h0010, 32'hDEADBEEF, 2'b00, rd, lat);
    check("wr_word_lat", lat, 2);
    check("wr_word_ld", rd, 32'h0);
    bus_xfer(1'b0, 2'b10, 16'h0010, 32'h0, 2'b00, rd, lat);
    check("rd_word_lat", lat, 2);
    check("rd_word", rd, 32'hDEADBEEF);

    // Byte lane write and narrow reads
    bus_xfer(1'b1, 2'b00, 16'h0013, 32'h000000AA, 2'b00, rd, lat);
    bus_xfer(1'b0, 2'b10, 16'h0010, 32'h0, 2'b00, rd, lat);
    check("rd_after_byte", rd, 32'hAAADBEEF);
    bus_xfer(1'b0, 2'b01, 16'h0012, 32'h0, 2'b00, rd, lat);
    check("rd_half_hi", rd, 32'h0000AAAD);
    bus_xfer(1'b0, 2'b01, 16'h0010, 32'h0, 2'b00, rd, lat);
    check("rd_half_lo", rd, 32'h0000BEEF);
    bus_xfer(1'b0, 2'b00, 16'h0013, 32'h0, 2'b00, rd, lat);
    check("rd_byte3", rd, 32'h000000AA);
    bus_xfer(1'b0, 2'b10, 16'h0410, 32'h0, 2'b00, rd, lat);
    check("rd_alias", rd, 32'hAAADBEEF);

    // Error cases: still complete, no write, zero data
    bus_xfer(1'b1, 2'b10, 16'h0011, 32'h12345678, 2'b00, rd, lat);
    check("err_wr_lat", lat, 2);
    check("err_wr_ld", rd, 32'h0);
    bus_xfer(1'b0, 2'b10, 16'h0010, 32'h0, 2'b00, rd, lat);
    check("rd_after_err", rd, 32'hAAADBEEF);
    bus_xfer(1'b0, 2'b01, 16'h0011, 32'h0, 2'b00, rd, lat);
    check("err_half_rd", rd, 32'h0);
    bus_xfer(1'b0, 2'b11, 16'h0010, 32'h0, 2'b00, rd, lat);
    check("err_size_rd", rd, 32'h0);

    // Interrupts
    bus_xfer(1'b1, 2'b10, 16'h8000, 32'h3, 2'b00, rd, lat);
    check("intr_set", {30'd0, intr_h}, 32'd3);
    intr_ack = 2'b01;
    @(negedge clk);
    intr_ack = 2'b00;
    check("intr_ack0", {30'd0, intr_h}, 32'd2);
    bus_xfer(1'b0, 2'b10, 16'h8004, 32'h0, 2'b00, rd, lat);
    check("mmio_stat", rd, 32'h2);
    bus_xfer(1'b0, 2'b10, 16'h8000, 32'h0, 2'b00, rd, lat);
    check("mmio_set_rd", rd, 32'h0);
    bus_xfer(1'b1, 2'b10, 16'h8000, 32'h1, 2'b01, rd, lat);
    check("set_wins", {30'd0, intr_h}, 32'd3);
    intr_ack = 2'b11;
    @(negedge clk);
    intr_ack = 2'b00;
    check("intr_clr_all", {30'd0, intr_h}, 32'd0);
    bus_xfer(1'b1, 2'b10, 16'h8004, 32'h3, 2'b00, rd, lat);
    check("stat_wr_ign", {30'd0, intr_h}, 32'd0);

    // bus_en held high for 6 cycles: one pulse only
    @(negedge clk);
    p0 = n_pulses;
    bus_en = 1'b1; bus_wen = 1'b0; bus_size = 2'b10; bus_addr = 16'h0010;
    repeat (6) @(negedge clk);
    bus_en = 1'b0;
    repeat (2) @(negedge clk);
    check("held_en_pulses", n_pulses - p0, 1);

    // Reset during WAIT of a write
    bus_xfer(1'b1, 2'b10, 16'h8000, 32'h3, 2'b00, rd, lat);
    check("pre_rst_intr", {30'd0, intr_h}, 32'd3);
    @(negedge clk);
    bus_en = 1'b1; bus_wen = 1'b1; bus_size = 2'b10; bus_addr = 16'h0010; store_data = 32'h55555555;
    @(negedge clk);
    check("in_wait", {30'd0, dbg_state}, 32'd1);
    p0 = n_pulses;
    reset_h = 1'b1; bus_en = 1'b0;
    @(negedge clk);
    reset_h = 1'b0; bus_wen = 1'b0;
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_intr", {30'd0, intr_h}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_pulse", n_pulses - p0, 0);
    bus_xfer(1'b0, 2'b10, 16'h0010, 32'h0, 2'b00, rd, lat);
    check("abort_ram", rd, 32'hAAADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning RAM depth in 32-bit words (power of 2, up to 8192).
REQ-002 SHALL have parameter WAIT_CYC, default 1, meaning wait cycles between request capture and bus_ready (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_h, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port bus_en, input, 1 bit: request valid, driven by the initiator.
REQ-006 SHALL have port bus_wen, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port bus_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 SHALL have port bus_addr, input, 16 bits: byte address.
REQ-009 SHALL have port store_data, input, 32 bits: write data, right-aligned.
REQ-010 SHALL have port bus_ready, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port load_data, output, 32 bits: read data, right-aligned and zero-extended.
REQ-012 SHALL have port intr_h, output, 2 bits: pending interrupt lines.
REQ-013 SHALL have port intr_ack, input, 2 bits: per-line interrupt acknowledge (level).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK, HOLD.
- IDLE: bus_en=1 captures addr, size, wen and store_data.
  - Goes to WAIT when WAIT_CYC>0, else to ACK.
REQ-015 WAIT SHALL count WAIT_CYC cycles, then go to ACK.
- Request inputs are ignored while in WAIT.
REQ-016 ACK SHALL assert bus_ready=1 for exactly one cycle, then go to HOLD.
- Latency from bus_en sampled in IDLE to bus_ready = WAIT_CYC+1 cycles.
REQ-017 HOLD SHALL wait for bus_en=0, then go to IDLE.
- bus_en held high after ACK never starts a second transfer.
REQ-018 load_data SHALL be valid only during the ACK cycle and SHALL be 0 in all other cycles.
REQ-019 bus_addr[15]=0 SHALL select RAM.
- Word index = bus_addr[log2(MEM_WORDS)+1:2]; higher address bits are ignored, so addresses alias (wrap-around).
REQ-020 Writes SHALL update only the addressed lanes:
- byte: lane addr[1:0] gets store_data[7:0];
- half: lanes {addr[1],0} and {addr[1],1} get store_data[15:0];
- word: all lanes get store_data[31:0].
REQ-021 Reads SHALL return the addressed lanes shifted down to bit 0, zero-extended.
REQ-022 Half with addr[0]=1, word with addr[1:0]≠0, or size=11 is an error. An error SHALL:
- still complete with bus_ready;
- suppress the write;
- return load_data=0.
REQ-023 bus_addr[15]=1 SHALL select MMIO; address bits [1:0] and bus_size are ignored.
- 0x8000 write: pending |= store_data[1:0]; read returns 0.
- 0x8004 read: returns {30'b0, pending}; writes ignored.
- Any other MMIO address: reads 0; writes ignored.
REQ-024 intr_h SHALL equal the pending register directly.
- pending[i] clears the cycle after intr_ack[i]=1 is sampled.
REQ-025 When a set (0x8000 write in ACK) and intr_ack[i] fall in the same cycle, the set SHALL win and pending[i]=1 afterwards.
REQ-026 Memory writes and pending updates SHALL take effect at the end of the ACK cycle.
- A read-after-write issued in the next transfer SHALL return the new data.

Reset
REQ-027 reset_h=1 SHALL force the following at the next edge:
- state = IDLE, wait counter = 0, bus_ready = 0, load_data = 0, pending = 0, intr_h = 0.
- RAM contents are not reset.
REQ-028 reset_h asserted in WAIT, ACK or HOLD SHALL abort the transfer.
- No bus_ready pulse follows.
- No write is committed unless the ACK edge has already passed.
REQ-029 reset_h SHALL take priority over bus_en and intr_ack in the same cycle.

Verification
REQ-030 With WAIT_CYC=1, the bench SHALL run: write word 0xDEADBEEF to 0x0010, then read word at 0x0010.
- Required: bus_ready 2 cycles after bus_en; load_data = 0xDEADBEEF in the ACK cycle and 0 otherwise.
REQ-031 The bench SHALL run: write byte 0xAA to 0x0013, then read word at 0x0010.
- Required: 0xAAADBEEF.
- Then read half at 0x0012: required 0x0000AAAD.
REQ-032 The bench SHALL run: write word 0x12345678 to 0x0011 (misaligned), then read word at 0x0010.
- Required: bus_ready pulses, RAM unchanged (0xAAADBEEF), load_data of the errored transfer = 0.
REQ-033 The bench SHALL run: write 0x3 to 0x8000, then pulse intr_ack=01 for one cycle.
- Required: intr_h=11, then 10.
- Then write 0x1 to 0x8000 with intr_ack=01 in the ACK cycle: required intr_h=11 (set wins).
REQ-034 The bench SHALL hold bus_en=1 for 6 cycles.
- Required: exactly one bus_ready pulse.
- Then assert reset_h during WAIT of a write: required no bus_ready pulse, RAM unchanged, intr_h=00.
